// File: rtl/execute_pipe.sv
// Registered EX stage: ALU result, zero flag and branch target into an EX/MEM output register.
// Latency 1 cycle for ALU ops; N cycles for MUL (iterative shift-add, only when EXECUTE_MUL_EN is defined).
// Valid/ready: the output register holds while out_valid & !out_ready; in_ready drops while full-and-stalled or multiplying.
module execute_pipe #(
    parameter int N         = 64,
    parameter int IMM_SHIFT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [N-1:0] operandB;
    logic [N-1:0] aluComb;
    logic [N-1:0] branchComb;
    logic         accept;
    logic         loadAlu;

    assign operandB   = AluSrc ? signImm_E : readData2_E;
    assign branchComb = PC_E + (signImm_E << IMM_SHIFT);
    assign accept     = in_valid && in_ready;

    // Single-cycle ALU; MUL and unknown codes give 0 here (MUL result comes from the iterative unit)
    always_comb begin
        aluComb = '0;
        case (AluControl)
            OP_AND:  aluComb = readData1_E & operandB;
            OP_OR:   aluComb = readData1_E | operandB;
            OP_ADD:  aluComb = readData1_E + operandB;
            OP_SUB:  aluComb = readData1_E - operandB;
            OP_PASS: aluComb = operandB;
            OP_NOR:  aluComb = ~(readData1_E | operandB);
            default: aluComb = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, MULT} state_t;

    state_t             state;
    state_t             stateNext;
    logic               isMul;
    logic               mulDone;
    logic [N-1:0]       mulA;
    logic [N-1:0]       mulB;
    logic [N-1:0]       mulAcc;
    logic [N-1:0]       mulPcBranch;
    logic [N-1:0]       mulWriteData;
    logic [CNT_W-1:0]   mulCnt;
    logic [N-1:0]       accStep;

    assign isMul   = (AluControl == 4'b1000);
    assign loadAlu = accept && !isMul;
    assign accStep = mulAcc + (mulB[0] ? mulA : '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and handshake: accept only when idle and the output slot frees up this edge
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        mulDone   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && isMul) begin
                    stateNext = MULT;
                end
            end
            MULT: begin
                if (mulCnt == CNT_W'(N - 1)) begin
                    mulDone   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Shift-add multiplier: latch operands at accept, then one multiplier bit per cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            mulA         <= '0;
            mulB         <= '0;
            mulAcc       <= '0;
            mulCnt       <= '0;
            mulPcBranch  <= '0;
            mulWriteData <= '0;
        end else if (accept && isMul) begin
            mulA         <= readData1_E;
            mulB         <= operandB;
            mulAcc       <= '0;
            mulCnt       <= '0;
            mulPcBranch  <= branchComb;
            mulWriteData <= readData2_E;
        end else if (state == MULT) begin
            mulAcc <= accStep;
            mulA   <= mulA << 1;
            mulB   <= mulB >> 1;
            mulCnt <= mulCnt + 1'b1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign loadAlu  = accept;
`endif

    // EX/MEM output register: load a new result, otherwise drop valid once drained, otherwise hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            aluResult_M <= '0;
            zero_M      <= 1'b0;
            PCBranch_M  <= '0;
            writeData_M <= '0;
        end else if (loadAlu) begin
            out_valid   <= 1'b1;
            aluResult_M <= aluComb;
            zero_M      <= (aluComb == '0);
            PCBranch_M  <= branchComb;
            writeData_M <= readData2_E;
        end
`ifdef EXECUTE_MUL_EN
        else if (mulDone) begin
            out_valid   <= 1'b1;
            aluResult_M <= accStep;
            zero_M      <= (accStep == '0);
            PCBranch_M  <= mulPcBranch;
            writeData_M <= mulWriteData;
        end
`endif
        else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;

    int total = 0;
    int bad   = 0;

    execute_pipe #(.N(N), .IMM_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .AluSrc(AluSrc), .AluControl(AluControl), .PC_E(PC_E), .signImm_E(signImm_E),
        .readData1_E(readData1_E), .readData2_E(readData2_E),
        .out_valid(out_valid), .out_ready(out_ready), .PCBranch_M(PCBranch_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic v, input logic src, input logic [3:0] ctrl,
                         input logic [N-1:0] pc, input logic [N-1:0] imm,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid    = v;
        AluSrc      = src;
        AluControl  = ctrl;
        PC_E        = pc;
        signImm_E   = imm;
        readData1_E = a;
        readData2_E = b;
    endtask

    initial begin
        int cyc;
        logic rdyLow;

        reset     = 1'b0;
        out_ready = 1'b1;
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        tick();
        tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_alu", aluResult_M, 64'd0);
        chk("rst_zero", {63'd0, zero_M}, 64'd0);
        chk("rst_pcb", PCBranch_M, 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD with immediate: 5 + 3, branch 1 + (3<<2)
        setIn(1'b1, 1'b1, 4'b0010, 64'd1, 64'd3, 64'd5, 64'h55);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", aluResult_M, 64'd8);
        chk("add_zero", {63'd0, zero_M}, 64'd0);
        chk("add_pcb", PCBranch_M, 64'd13);
        chk("add_wdata", writeData_M, 64'h55);

        // Reset mid-traffic: output valid and a new op presented at the same edge
        setIn(1'b1, 1'b1, 4'b0010, 64'd1, 64'd3, 64'd5, 64'h55);
        reset = 1'b0;
        tick();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_alu", aluResult_M, 64'd0);
        chk("midrst_wdata", writeData_M, 64'd0);
        reset = 1'b1;
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        tick();
        chk("idle_valid", {63'd0, out_valid}, 64'd0);

        // SUB equal operands -> zero
        setIn(1'b1, 1'b0, 4'b0110, 64'h100, 64'd0, 64'hFF00_0000_0000_000F, 64'hFF00_0000_0000_000F);
        tick();
        chk("sub_result", aluResult_M, 64'd0);
        chk("sub_zero", {63'd0, zero_M}, 64'd1);
        chk("sub_wdata", writeData_M, 64'hFF00_0000_0000_000F);
        chk("sub_pcb", PCBranch_M, 64'h100);

        // Back-to-back OR while the SUB result drains
        setIn(1'b1, 1'b0, 4'b0001, 64'd0, 64'd0, 64'hF0, 64'h0F);
        #1;
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("or_result", aluResult_M, 64'hFF);
        chk("or_valid", {63'd0, out_valid}, 64'd1);

        // Backpressure: AND queued, downstream stalled three cycles
        setIn(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0, 64'hFF, 64'h0F);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            chk("bp_frozen", aluResult_M, 64'hFF);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        chk("bp_and_result", aluResult_M, 64'h0F);
        chk("bp_and_valid", {63'd0, out_valid}, 64'd1);
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // NOR of zeros
        setIn(1'b1, 1'b0, 4'b1100, 64'd0, 64'd0, 64'd0, 64'd0);
        tick();
        chk("nor_result", aluResult_M, {N{1'b1}});
        // pass B = imm of -1, branch 0x10 - 4
        setIn(1'b1, 1'b1, 4'b0111, 64'h10, {N{1'b1}}, 64'd9, 64'd0);
        tick();
        chk("pass_result", aluResult_M, {N{1'b1}});
        chk("pass_pcb", PCBranch_M, 64'hC);
        // ADD wraps to zero; immediate shift drops high bits
        setIn(1'b1, 1'b0, 4'b0010, 64'd0, 64'hC000_0000_0000_0001, {N{1'b1}}, 64'd1);
        tick();
        chk("wrap_result", aluResult_M, 64'd0);
        chk("wrap_zero", {63'd0, zero_M}, 64'd1);
        chk("shift_pcb", PCBranch_M, 64'd4);
        // Unknown op code
        setIn(1'b1, 1'b0, 4'b0101, 64'd0, 64'd0, 64'd3, 64'd4);
        tick();
        chk("unk_result", aluResult_M, 64'd0);
        chk("unk_zero", {63'd0, zero_M}, 64'd1);
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        tick();

`ifdef EXECUTE_MUL_EN
        // MUL 7*6, N-cycle latency with in_ready held low
        setIn(1'b1, 1'b0, 4'b1000, 64'h20, 64'd1, 64'd7, 64'd6);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        cyc = 0;
        rdyLow = 1'b1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready !== 1'b0) rdyLow = 1'b0;
            tick();
            cyc++;
        end
        chk("mul_latency", 64'(cyc), 64'(N));
        chk("mul_ready_low", {63'd0, rdyLow}, 64'd1);
        chk("mul_result", aluResult_M, 64'd42);
        chk("mul_pcb", PCBranch_M, 64'h24);
        chk("mul_wdata", writeData_M, 64'd6);
        tick();
        // MUL overflow: 2^63 * 2 -> 0
        setIn(1'b1, 1'b1, 4'b1000, 64'd0, 64'd2, 64'h8000_0000_0000_0000, 64'd0);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        for (int i = 0; i < N; i++) tick();
        chk("mul_ovf_valid", {63'd0, out_valid}, 64'd1);
        chk("mul_ovf_result", aluResult_M, 64'd0);
        chk("mul_ovf_zero", {63'd0, zero_M}, 64'd1);
        tick();
        // Reset during a MUL
        setIn(1'b1, 1'b0, 4'b1000, 64'd0, 64'd0, 64'd7, 64'd6);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        chk("mulrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mulrst_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b1;
        setIn(1'b1, 1'b1, 4'b0010, 64'd0, 64'd3, 64'd5, 64'd0);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        chk("mulrst_add_valid", {63'd0, out_valid}, 64'd1);
        chk("mulrst_add_result", aluResult_M, 64'd8);
        for (int i = 0; i < N + 2; i++) tick();
        chk("mulrst_no_late", {63'd0, out_valid}, 64'd0);
`else
        // Without the multiplier, 1000 is an unknown op with latency 1
        setIn(1'b1, 1'b0, 4'b1000, 64'h20, 64'd1, 64'd7, 64'd6);
        #1;
        chk("mul_off_ready", {63'd0, in_ready}, 64'd1);
        tick();
        setIn(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
        chk("mul_off_valid", {63'd0, out_valid}, 64'd1);
        chk("mul_off_result", aluResult_M, 64'd0);
        chk("mul_off_zero", {63'd0, zero_M}, 64'd1);
        chk("mul_off_pcb", PCBranch_M, 64'h24);
        tick();
        chk("mul_off_drain", {63'd0, out_valid}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
